hex_scroller: RTL and testbench

HEX_SCROLLER -- requirements
Module: hex_scroller

---
 rtl/hex_scroller.sv | 108 ++++++++++
 tb/tb_hex_scroller.sv | 135 +++++++++++++
 2 files changed

// File: rtl/hex_scroller.sv
// Scrolls a 64-bit value, one nibble per step, across a NUM_DIGITS-wide hex display window.
// Window digits past nibble 15 are blanked rather than wrapped.
module hex_scroller #(
   parameter int NUM_DIGITS = 6,
   parameter int TICK_DIV   = 25000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [63:0]             data_in,
   input  logic                    load,
   input  logic                    loop,
   input  logic                    hold,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   blank,
   output logic [3:0]              pos,
   output logic                    busy,
   output logic                    done
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   typedef enum logic {IDLE, SCROLL} state_t;

   state_t                  state, state_n;
   logic [63:0]             cap, cap_n;
   logic [TW-1:0]           tick, tick_n;
   logic [3:0]              pos_n;
   logic                    loop_flag, loop_n;
   logic                    done_n;
   logic [4*NUM_DIGITS-1:0] digits_n;
   logic [NUM_DIGITS-1:0]   blank_n;
   logic [4:0]              idx;
   logic [3:0]              nib;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cap       <= '0;
         tick      <= '0;
         pos       <= '0;
         loop_flag <= 1'b0;
         digits    <= '0;
         blank     <= '1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         cap       <= cap_n;
         tick      <= tick_n;
         pos       <= pos_n;
         loop_flag <= loop_n;
         digits    <= digits_n;
         blank     <= blank_n;
         busy      <= (state_n == SCROLL);
         done      <= done_n;
      end
   end

   // Display outputs are built from next-state values so they line up with pos and busy.
   always_comb begin
      state_n  = state;
      cap_n    = cap;
      tick_n   = tick;
      pos_n    = pos;
      loop_n   = loop_flag;
      done_n   = 1'b0;
      digits_n = '0;
      blank_n  = '1;
      idx      = '0;
      nib      = '0;

      if (load) begin
         state_n = SCROLL;
         cap_n   = data_in;
         loop_n  = loop;
         pos_n   = '0;
         tick_n  = '0;
      end else if (state == SCROLL && !hold) begin
         if (tick == TICK_LAST) begin
            tick_n = '0;
            if (pos == 4'd15) begin
               pos_n = '0;
               if (!loop_flag) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end else begin
               pos_n = pos + 4'd1;
            end
         end else begin
            tick_n = tick + TW'(1);
         end
      end

      if (state_n == SCROLL) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            idx = {1'b0, pos_n} + 5'(k);
            nib = 4'(cap_n >> {(4'd15 - idx[3:0]), 2'b00});
            if (idx <= 5'd15) begin
               digits_n[4*(NUM_DIGITS-1-k) +: 4] = nib;
               blank_n[NUM_DIGITS-1-k]           = 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_hex_scroller.sv
// Directed bench for hex_scroller with NUM_DIGITS=6, TICK_DIV=4.
module tb_hex_scroller;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] data_in;
   logic        load, loop, hold;
   logic [23:0] digits;
   logic [5:0]  blank;
   logic [3:0]  pos;
   logic        busy, done;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] PATTERN = 64'h0123456789ABCDEF;

   hex_scroller #(.NUM_DIGITS(6), .TICK_DIV(4)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .load(load), .loop(loop),
      .hold(hold), .digits(digits), .blank(blank), .pos(pos), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, returning at the following falling edge.
   task automatic applyStimulus(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkWindow(input string tag, input logic [3:0] ep, input logic [23:0] ed,
                              input logic [5:0] eb, input logic ebusy, input logic edone);
      checkOutput({tag, " pos"}, 64'(pos), 64'(ep));
      checkOutput({tag, " digits"}, 64'(digits), 64'(ed));
      checkOutput({tag, " blank"}, 64'(blank), 64'(eb));
      checkOutput({tag, " busy"}, 64'(busy), 64'(ebusy));
      checkOutput({tag, " done"}, 64'(done), 64'(edone));
   endtask

   initial begin
      rst = 1'b1; data_in = '0; load = 1'b0; loop = 1'b0; hold = 1'b0;
      #12;
      checkWindow("reset", 4'd0, 24'h0, 6'h3F, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1);
      checkWindow("idle", 4'd0, 24'h0, 6'h3F, 1'b0, 1'b0);

      // Single pass.
      data_in = PATTERN; loop = 1'b0; load = 1'b1;
      applyStimulus(1);
      load = 1'b0; data_in = 64'hDEAD_BEEF_CAFE_F00D;
      checkWindow("load", 4'd0, 24'h012345, 6'h00, 1'b1, 1'b0);
      applyStimulus(3);
      checkWindow("tick3", 4'd0, 24'h012345, 6'h00, 1'b1, 1'b0);
      applyStimulus(1);
      checkWindow("pos1", 4'd1, 24'h123456, 6'h00, 1'b1, 1'b0);
      applyStimulus(40);
      checkWindow("pos11", 4'd11, 24'hBCDEF0, 6'h01, 1'b1, 1'b0);
      applyStimulus(16);
      checkWindow("pos15", 4'd15, 24'hF00000, 6'h1F, 1'b1, 1'b0);
      applyStimulus(3);
      checkWindow("pos15end", 4'd15, 24'hF00000, 6'h1F, 1'b1, 1'b0);
      applyStimulus(1);
      checkWindow("done", 4'd0, 24'h0, 6'h3F, 1'b0, 1'b1);
      applyStimulus(1);
      checkWindow("doneoff", 4'd0, 24'h0, 6'h3F, 1'b0, 1'b0);

      // Looping pass: 17 steps with no done.
      data_in = PATTERN; loop = 1'b1; load = 1'b1;
      applyStimulus(1);
      load = 1'b0; loop = 1'b0;
      checkWindow("loopload", 4'd0, 24'h012345, 6'h00, 1'b1, 1'b0);
      for (int s = 1; s <= 17; s++) begin
         for (int c = 0; c < 4; c++) begin
            applyStimulus(1);
            checkOutput("loop done", 64'(done), 64'd0);
            checkOutput("loop busy", 64'(busy), 64'd1);
         end
         checkOutput("loop pos", 64'(pos), 64'(s % 16));
      end

      // Hold at pos 3 with one tick already counted.
      applyStimulus(8);
      checkWindow("pos3", 4'd3, 24'h345678, 6'h00, 1'b1, 1'b0);
      applyStimulus(1);
      hold = 1'b1;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1);
         checkWindow("hold", 4'd3, 24'h345678, 6'h00, 1'b1, 1'b0);
      end
      hold = 1'b0;
      applyStimulus(2);
      checkWindow("release2", 4'd3, 24'h345678, 6'h00, 1'b1, 1'b0);
      applyStimulus(1);
      checkWindow("release3", 4'd4, 24'h456789, 6'h00, 1'b1, 1'b0);
      hold = 1'b1; load = 1'b1; data_in = 64'hFEDCBA9876543210; loop = 1'b0;
      applyStimulus(1);
      load = 1'b0; hold = 1'b0;
      checkWindow("holdload", 4'd0, 24'hFEDCBA, 6'h00, 1'b1, 1'b0);

      // Asynchronous reset mid-pass at pos 7.
      data_in = PATTERN; load = 1'b1;
      applyStimulus(1);
      load = 1'b0;
      applyStimulus(28);
      checkWindow("pos7", 4'd7, 24'h789ABC, 6'h00, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 checkWindow("asyncrst", 4'd0, 24'h0, 6'h3F, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         applyStimulus(1);
         checkOutput("postrst done", 64'(done), 64'd0);
      end
      checkWindow("postrst idle", 4'd0, 24'h0, 6'h3F, 1'b0, 1'b0);
      load = 1'b1;
      applyStimulus(1);
      load = 1'b0;
      checkWindow("fresh", 4'd0, 24'h012345, 6'h00, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
